// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage valid/allowin controller with a single-outstanding
// SRAM-like data-memory handshake (req/addr_ok/data_ok), load-data
// buffering while WB is stalled, and flush draining of in-flight responses.
module mem_stage_ctrl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          exe_to_mem_valid,
    output logic          mem_allowin,
    output logic          mem_valid,
    input  logic          wb_allowin,
    output logic          mem_to_wb_valid,
    input  logic          mem_access,
    input  logic          mem_store,
    input  logic          mem_ex,
    input  logic          flush,
    output logic          dmem_req,
    output logic          dmem_wr,
    input  logic          dmem_addr_ok,
    input  logic          dmem_data_ok,
    input  logic [DW-1:0] dmem_rdata,
    output logic [DW-1:0] load_data,
    output logic          load_data_valid
);

    // IDLE : no transaction outstanding, a request may be issued
    // WAIT : request accepted, waiting for data_ok
    // DONE : response captured in r_rdata_buf, WB not yet accepting
    // DRAIN: instruction flushed while a response is still in flight
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_mem_valid;
    logic [DW-1:0]   r_rdata_buf;

    logic            w_in_idle;
    logic            w_in_wait;
    logic            w_in_done;
    logic            w_in_drain;
    logic            w_resp_now;
    logic            w_req;
    logic            w_ready_go;
    logic            w_to_wb;
    logic            w_allowin;

    assign w_in_idle  = (r_state == S_IDLE);
    assign w_in_wait  = (r_state == S_WAIT);
    assign w_in_done  = (r_state == S_DONE);
    assign w_in_drain = (r_state == S_DRAIN);

    // Response arriving for the live instruction this cycle.
    assign w_resp_now = w_in_wait & dmem_data_ok;

    // A request only leaves from IDLE; a same-cycle flush suppresses it so
    // the memory never sees a transaction for a killed instruction.
    assign w_req = w_in_idle & r_mem_valid & mem_access & ~mem_ex & ~flush;

    // Non-memory and excepting instructions finish immediately; memory
    // instructions finish when the response is present or buffered.
    assign w_ready_go = mem_ex | ~mem_access | w_in_done | w_resp_now;

    assign w_to_wb = r_mem_valid & w_ready_go & ~flush;

    // DRAIN blocks entry so the stale response cannot be mistaken for the
    // next instruction's response.
    assign w_allowin = ~w_in_drain & (~r_mem_valid | (w_ready_go & wb_allowin));

    assign mem_allowin     = w_allowin;
    assign mem_valid       = r_mem_valid;
    assign mem_to_wb_valid = w_to_wb;
    assign dmem_req        = w_req;
    assign dmem_wr         = w_req & mem_store;
    assign load_data_valid = w_to_wb & mem_access & ~mem_store & ~mem_ex;

    // Select live response data, the buffered response, or zero.
    always_comb begin
        load_data = '0;
        if (w_resp_now) begin
            load_data = dmem_rdata;
        end else if (w_in_done) begin
            load_data = r_rdata_buf;
        end
    end

    // Occupancy of the MEM stage: flush kills, allowin loads, else hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
        end else if (flush) begin
            r_mem_valid <= 1'b0;
        end else if (w_allowin) begin
            r_mem_valid <= exe_to_mem_valid;
        end
    end

    // Memory handshake sequencer and response capture buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_rdata_buf <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req && dmem_addr_ok) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush && !dmem_data_ok) begin
                        r_state <= S_DRAIN;
                    end else if (flush && dmem_data_ok) begin
                        r_state <= S_IDLE;
                    end else if (dmem_data_ok && wb_allowin) begin
                        r_state <= S_IDLE;
                    end else if (dmem_data_ok) begin
                        r_state     <= S_DONE;
                        r_rdata_buf <= dmem_rdata;
                    end
                end
                S_DONE: begin
                    if (flush || wb_allowin) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (dmem_data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed stimulus pushes expected
// WB transfers and memory requests into queues; a negedge monitor pops and
// compares them whenever the DUT presents a transfer or an accepted request.
module tb_mem_stage_ctrl;

    localparam int DW = 32;

    logic          clk;
    logic          resetn;
    logic          exe_to_mem_valid;
    logic          mem_allowin;
    logic          mem_valid;
    logic          wb_allowin;
    logic          mem_to_wb_valid;
    logic          mem_access;
    logic          mem_store;
    logic          mem_ex;
    logic          flush;
    logic          dmem_req;
    logic          dmem_wr;
    logic          dmem_addr_ok;
    logic          dmem_data_ok;
    logic [DW-1:0] dmem_rdata;
    logic [DW-1:0] load_data;
    logic          load_data_valid;

    mem_stage_ctrl #(.DW(DW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .exe_to_mem_valid (exe_to_mem_valid),
        .mem_allowin      (mem_allowin),
        .mem_valid        (mem_valid),
        .wb_allowin       (wb_allowin),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .mem_access       (mem_access),
        .mem_store        (mem_store),
        .mem_ex           (mem_ex),
        .flush            (flush),
        .dmem_req         (dmem_req),
        .dmem_wr          (dmem_wr),
        .dmem_addr_ok     (dmem_addr_ok),
        .dmem_data_ok     (dmem_data_ok),
        .dmem_rdata       (dmem_rdata),
        .load_data        (load_data),
        .load_data_valid  (load_data_valid)
    );

    typedef struct {
        logic          ldv;
        logic [DW-1:0] data;
    } xfer_t;

    xfer_t tq[$];
    logic  rq[$];
    xfer_t mon_e;
    logic  mon_wr;

    int nchk = 0;
    int nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Monitor: compare each WB transfer and each accepted memory request.
    always @(negedge clk) begin
        if (resetn) begin
            if (mem_to_wb_valid && wb_allowin) begin
                if (tq.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL xfer_unexpected: got transfer ldv=%b data=%h expected none",
                             load_data_valid, load_data);
                end else begin
                    mon_e = tq.pop_front();
                    chk1("xfer_ldv", load_data_valid, mon_e.ldv);
                    if (mon_e.ldv) chk32("xfer_data", load_data, mon_e.data);
                end
            end
            if (dmem_req && dmem_addr_ok) begin
                if (rq.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL req_unexpected: got request wr=%b expected none", dmem_wr);
                end else begin
                    mon_wr = rq.pop_front();
                    chk1("req_wr", dmem_wr, mon_wr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        resetn           = 1'b0;
        exe_to_mem_valid = 1'b0;
        wb_allowin       = 1'b1;
        mem_access       = 1'b0;
        mem_store        = 1'b0;
        mem_ex           = 1'b0;
        flush            = 1'b0;
        dmem_addr_ok     = 1'b0;
        dmem_data_ok     = 1'b0;
        dmem_rdata       = '0;

        // Reset state
        samp();
        chk1("rst_mem_valid", mem_valid, 1'b0);
        chk1("rst_allowin", mem_allowin, 1'b1);
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_wr", dmem_wr, 1'b0);
        chk1("rst_to_wb", mem_to_wb_valid, 1'b0);
        chk1("rst_ldv", load_data_valid, 1'b0);
        chk32("rst_load_data", load_data, 32'h0);
        tick();
        resetn = 1'b1;

        // ALU ops streaming through
        exe_to_mem_valid = 1'b1;
        mem_access       = 1'b0;
        for (int i = 0; i < 3; i++) tq.push_back('{1'b0, 32'h0});
        samp();
        chk1("alu_allowin_entry", mem_allowin, 1'b1);
        chk1("alu_valid_entry", mem_valid, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) exe_to_mem_valid = 1'b0;
            samp();
            chk1("alu_to_wb", mem_to_wb_valid, 1'b1);
            chk1("alu_allowin", mem_allowin, 1'b1);
            chk1("alu_req", dmem_req, 1'b0);
        end
        tick();
        samp();
        chk1("alu_drained", mem_valid, 1'b0);

        // Load: addr_ok one cycle late, data_ok two cycles after accept
        tick();
        exe_to_mem_valid = 1'b1;
        tq.push_back('{1'b1, 32'hDEADBEEF});
        rq.push_back(1'b0);
        samp();
        chk1("ld_entry_req", dmem_req, 1'b0);
        tick();
        exe_to_mem_valid = 1'b0;
        mem_access = 1'b1;
        mem_store  = 1'b0;
        samp();
        chk1("ld_req_c1", dmem_req, 1'b1);
        chk1("ld_wr_c1", dmem_wr, 1'b0);
        chk1("ld_allowin_c1", mem_allowin, 1'b0);
        chk1("ld_to_wb_c1", mem_to_wb_valid, 1'b0);
        tick();
        dmem_addr_ok = 1'b1;
        samp();
        chk1("ld_req_c2", dmem_req, 1'b1);
        tick();
        dmem_addr_ok = 1'b0;
        samp();
        chk1("ld_req_wait", dmem_req, 1'b0);
        chk1("ld_allowin_wait", mem_allowin, 1'b0);
        chk1("ld_to_wb_wait", mem_to_wb_valid, 1'b0);
        tick();
        dmem_data_ok = 1'b1;
        dmem_rdata   = 32'hDEADBEEF;
        samp();
        chk1("ld_to_wb_resp", mem_to_wb_valid, 1'b1);
        chk32("ld_data_resp", load_data, 32'hDEADBEEF);
        chk1("ld_ldv_resp", load_data_valid, 1'b1);
        chk1("ld_allowin_resp", mem_allowin, 1'b1);
        tick();
        dmem_data_ok = 1'b0;
        dmem_rdata   = '0;
        samp();
        chk1("ld_done_valid", mem_valid, 1'b0);
        chk32("ld_done_data", load_data, 32'h0);

        // Load with WB stalled for 3 cycles on the response
        tick();
        exe_to_mem_valid = 1'b1;
        mem_access = 1'b0;
        tq.push_back('{1'b1, 32'hDEADBEEF});
        rq.push_back(1'b0);
        samp();
        tick();
        exe_to_mem_valid = 1'b0;
        mem_access   = 1'b1;
        dmem_addr_ok = 1'b1;
        samp();
        chk1("stl_req", dmem_req, 1'b1);
        tick();
        dmem_addr_ok = 1'b0;
        dmem_data_ok = 1'b1;
        dmem_rdata   = 32'hDEADBEEF;
        wb_allowin   = 1'b0;
        samp();
        chk1("stl_to_wb_resp", mem_to_wb_valid, 1'b1);
        chk1("stl_allowin_resp", mem_allowin, 1'b0);
        chk32("stl_data_resp", load_data, 32'hDEADBEEF);
        tick();
        dmem_data_ok = 1'b0;
        dmem_rdata   = 32'h12345678;
        samp();
        chk32("stl_buf_data1", load_data, 32'hDEADBEEF);
        chk1("stl_to_wb1", mem_to_wb_valid, 1'b1);
        chk1("stl_allowin1", mem_allowin, 1'b0);
        chk1("stl_req1", dmem_req, 1'b0);
        tick();
        samp();
        chk32("stl_buf_data2", load_data, 32'hDEADBEEF);
        chk1("stl_to_wb2", mem_to_wb_valid, 1'b1);
        tick();
        wb_allowin       = 1'b1;
        exe_to_mem_valid = 1'b1;
        rq.push_back(1'b1);
        samp();
        chk1("stl_to_wb_rel", mem_to_wb_valid, 1'b1);
        chk32("stl_data_rel", load_data, 32'hDEADBEEF);
        chk1("stl_ldv_rel", load_data_valid, 1'b1);
        chk1("stl_allowin_rel", mem_allowin, 1'b1);

        // Store enters back-to-back and issues from IDLE next cycle
        tick();
        exe_to_mem_valid = 1'b0;
        mem_access   = 1'b1;
        mem_store    = 1'b1;
        dmem_addr_ok = 1'b1;
        dmem_rdata   = '0;
        samp();
        chk1("st_req", dmem_req, 1'b1);
        chk1("st_wr", dmem_wr, 1'b1);
        chk1("st_valid", mem_valid, 1'b1);
        chk1("st_to_wb", mem_to_wb_valid, 1'b0);

        // Flush while WAIT, response arrives two cycles later
        tick();
        dmem_addr_ok = 1'b0;
        flush        = 1'b1;
        samp();
        chk1("fl_to_wb", mem_to_wb_valid, 1'b0);
        chk1("fl_req", dmem_req, 1'b0);
        tick();
        flush            = 1'b0;
        exe_to_mem_valid = 1'b1;
        samp();
        chk1("drn_valid", mem_valid, 1'b0);
        chk1("drn_allowin", mem_allowin, 1'b0);
        tick();
        dmem_data_ok = 1'b1;
        dmem_rdata   = 32'hBAD0BAD0;
        samp();
        chk1("drn_allowin_resp", mem_allowin, 1'b0);
        chk1("drn_to_wb_resp", mem_to_wb_valid, 1'b0);
        chk1("drn_ldv_resp", load_data_valid, 1'b0);
        tick();
        dmem_data_ok     = 1'b0;
        dmem_rdata       = '0;
        exe_to_mem_valid = 1'b0;
        samp();
        chk1("drn_allowin_after", mem_allowin, 1'b1);
        chk1("drn_valid_after", mem_valid, 1'b0);

        // Excepting load: no request, completes at once without load data
        tick();
        exe_to_mem_valid = 1'b1;
        mem_access = 1'b0;
        mem_store  = 1'b0;
        tq.push_back('{1'b0, 32'h0});
        samp();
        tick();
        exe_to_mem_valid = 1'b0;
        mem_access   = 1'b1;
        mem_ex       = 1'b1;
        dmem_addr_ok = 1'b1;
        samp();
        chk1("ex_req", dmem_req, 1'b0);
        chk1("ex_to_wb", mem_to_wb_valid, 1'b1);
        chk1("ex_ldv", load_data_valid, 1'b0);
        chk1("ex_allowin", mem_allowin, 1'b1);
        tick();
        mem_ex       = 1'b0;
        mem_access   = 1'b0;
        dmem_addr_ok = 1'b0;
        samp();
        chk1("ex_after_valid", mem_valid, 1'b0);

        // Asynchronous reset while WAIT
        tick();
        exe_to_mem_valid = 1'b1;
        rq.push_back(1'b0);
        samp();
        tick();
        exe_to_mem_valid = 1'b0;
        mem_access   = 1'b1;
        dmem_addr_ok = 1'b1;
        samp();
        chk1("ar_req", dmem_req, 1'b1);
        tick();
        dmem_addr_ok = 1'b0;
        samp();
        chk1("ar_wait_allowin", mem_allowin, 1'b0);
        tick();
        dmem_data_ok = 1'b1;
        dmem_rdata   = 32'hDEADBEEF;
        resetn       = 1'b0;
        #1;
        chk1("ar_valid", mem_valid, 1'b0);
        chk1("ar_allowin", mem_allowin, 1'b1);
        chk1("ar_to_wb", mem_to_wb_valid, 1'b0);
        chk1("ar_ldv", load_data_valid, 1'b0);
        chk32("ar_load_data", load_data, 32'h0);
        chk1("ar_req_rst", dmem_req, 1'b0);
        chk1("ar_wr_rst", dmem_wr, 1'b0);
        samp();
        tick();
        resetn           = 1'b1;
        dmem_data_ok     = 1'b0;
        dmem_rdata       = '0;
        exe_to_mem_valid = 1'b1;
        rq.push_back(1'b0);
        tq.push_back('{1'b1, 32'hCAFEF00D});
        samp();
        tick();
        exe_to_mem_valid = 1'b0;
        dmem_addr_ok = 1'b1;
        samp();
        chk1("ar_next_req", dmem_req, 1'b1);
        tick();
        dmem_addr_ok = 1'b0;
        dmem_data_ok = 1'b1;
        dmem_rdata   = 32'hCAFEF00D;
        samp();
        chk32("ar_next_data", load_data, 32'hCAFEF00D);
        chk1("ar_next_ldv", load_data_valid, 1'b1);
        tick();
        dmem_data_ok = 1'b0;
        dmem_rdata   = '0;
        mem_access   = 1'b0;
        samp();
        chk1("ar_next_done", mem_valid, 1'b0);

        // Flush in the same cycle as the request: no transaction created
        tick();
        exe_to_mem_valid = 1'b1;
        samp();
        tick();
        exe_to_mem_valid = 1'b0;
        mem_access   = 1'b1;
        flush        = 1'b1;
        dmem_addr_ok = 1'b1;
        samp();
        chk1("fr_req", dmem_req, 1'b0);
        chk1("fr_wr", dmem_wr, 1'b0);
        chk1("fr_to_wb", mem_to_wb_valid, 1'b0);
        tick();
        flush        = 1'b0;
        dmem_addr_ok = 1'b0;
        samp();
        chk1("fr_valid", mem_valid, 1'b0);
        chk1("fr_allowin", mem_allowin, 1'b1);
        chk1("fr_req_after", dmem_req, 1'b0);

        tick();
        samp();
        chk32("xfer_queue_empty", 32'(tq.size()), 32'h0);
        chk32("req_queue_empty", 32'(rq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
